// File: rtl/priority_encode8.sv
`default_nettype none
// ============================================================================
// Module      : priority_encode8
// Description : 8-input highest-priority encoder. Reports the index of the
//               most-significant set bit of the request vector plus a zero
//               flag, both combinationally (same-cycle) and as a registered
//               copy with load enable for pipelined consumers.
// Ports       : clk    - system clock, registers update on rising edge
//               rst    - synchronous active-high reset (priority over en)
//               en     - load enable for code_q / z_q
//               in     - request vector, bit 7 highest priority
//               code   - combinational index of highest set bit of in
//               z      - combinational zero flag (1 when in == 0)
//               code_q - registered copy of code
//               z_q    - registered copy of z
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encode8 #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  in,
    output logic [CODE_W-1:0] code,
    output logic              z,
    output logic [CODE_W-1:0] code_q,
    output logic              z_q
);

    logic [CODE_W-1:0] w_code;
    logic              w_z;
    logic [CODE_W-1:0] r_code_q;
    logic              r_z_q;

    // Scan from the lowest bit upward so that the last hit, i.e. the highest
    // set bit, wins. The defaults describe the all-zero request vector.
    always_comb begin
        w_code = '0;
        w_z    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                w_code = CODE_W'(i);
                w_z    = 1'b0;
            end
        end
    end

    // Registered copy; reset wins over the load enable, and the reset values
    // match the combinational result for an empty request vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_q <= '0;
            r_z_q    <= 1'b1;
        end else if (en) begin
            r_code_q <= w_code;
            r_z_q    <= w_z;
        end
    end

    assign code   = w_code;
    assign z      = w_z;
    assign code_q = r_code_q;
    assign z_q    = r_z_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_encode8.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encode8
// Description : Self-checking bench for priority_encode8. Stimulus pushes
//               expected results into scoreboard queues; independent monitor
//               processes pop and compare against the DUT outputs. Expected
//               values come from a log2-style reference of the priority rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encode8;

    typedef struct packed {
        logic [2:0] code;
        logic       z;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic [2:0] code;
    logic       z;
    logic [2:0] code_q;
    logic       z_q;

    exp_t comb_q[$];
    exp_t reg_q[$];
    event ev_comb;
    bit   reg_phase;
    int   checks;
    int   errors;

    // registered-path reference state
    logic [2:0] m_code_q;
    logic       m_z_q;

    priority_encode8 #(.WIDTH(8), .CODE_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .in     (in),
        .code   (code),
        .z      (z),
        .code_q (code_q),
        .z_q    (z_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of the highest set bit = floor(log2(v)); 0 for v == 0.
    function automatic logic [2:0] ref_code(input logic [7:0] v);
        int n;
        int x;
        n = 0;
        x = int'(v);
        while (x > 1) begin
            x = x >> 1;
            n++;
        end
        return 3'(n);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (in=%02h t=%0t)", name, act, exp, in, $time);
        end
    endtask

    // Combinational monitor: compares after each settle notification.
    initial begin
        exp_t e;
        forever begin
            @(ev_comb);
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                chk("comb_code", 8'(code), 8'(e.code));
                chk("comb_z", 8'(z), 8'(e.z));
            end
        end
    end

    // Clocked monitor: samples at the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                chk("code_q", 8'(code_q), 8'(e.code));
                chk("z_q", 8'(z_q), 8'(e.z));
                if (z_q === 1'b1)
                    chk("inv_zq_codeq", 8'(code_q), 8'd0);
            end
            if (reg_phase) begin
                chk("run_code", 8'(code), 8'(ref_code(in)));
                chk("run_z", 8'(z), 8'(in == 8'd0));
                if (z === 1'b0) begin
                    chk("inv_bit_set", 8'(in[code]), 8'd1);
                    chk("inv_upper_clear", 8'(int'(in) >> (int'(code) + 1)), 8'd0);
                end
            end
        end
    end

    task automatic comb_apply(input logic [7:0] v);
        in = v;
        #5;
        comb_q.push_back({ref_code(v), (v == 8'd0)});
        -> ev_comb;
        #1;
    endtask

    // Called just after a rising edge: drive, advance one edge, model it.
    task automatic step(input logic r, input logic e, input logic [7:0] v);
        #2;
        rst = r;
        en  = e;
        in  = v;
        @(posedge clk);
        if (r) begin
            m_code_q = 3'd0;
            m_z_q    = 1'b1;
        end else if (e) begin
            m_code_q = ref_code(v);
            m_z_q    = (v == 8'd0);
        end
        reg_q.push_back({m_code_q, m_z_q});
    endtask

    initial begin
        int wait_cycles;
        checks    = 0;
        errors    = 0;
        reg_phase = 1'b0;
        rst       = 1'b1;
        en        = 1'b0;
        in        = 8'd0;
        m_code_q  = 3'd0;
        m_z_q     = 1'b1;

        // Exhaustive combinational sweep (covers the 8..15, 16..31, 0, 1, 128..255 spots).
        for (int v = 0; v < 256; v++) comb_apply(8'(v));
        // Walking one, then walking one with all lower bits set.
        for (int k = 0; k < 8; k++) comb_apply(8'(1 << k));
        for (int k = 0; k < 8; k++) comb_apply(8'((2 << k) - 1));

        @(posedge clk);
        reg_phase = 1'b1;

        // Reset held two cycles with en = 1 and a full request vector.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        // Capture, then hold across three disabled edges.
        step(1'b0, 1'b1, 8'h2C);
        step(1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b0, 8'h01);
        // Mid-stream reset with changing input.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom_range(1, 255)));
        step(1'b1, 1'b1, 8'($urandom_range(1, 255)));
        step(1'b0, 1'b1, 8'($urandom_range(1, 255)));
        // Random traffic.
        for (int i = 0; i < 1000; i++)
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));

        wait_cycles = 0;
        while ((reg_q.size() > 0 || comb_q.size() > 0) && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #6;
        if (reg_q.size() > 0 || comb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d reg and %0d comb entries left, expected 0", reg_q.size(), comb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
